mem_wr_arbiter: RTL and testbench

Two-requester AXI-Stream write arbiter that shares the single write stream port of the on-chip stream memory between two producers. Grants whole packets: once a requester wins, it keeps the port until its tlast beat is accepted, so packets never interleave at the memory. Requesters are selected round-robin by default. The block sits directly in front of the memory's slave write port, with no buffering in the data path.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_pick.sv | 40 ++++
 rtl/mem_wr_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_wr_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : shared types and constants for the stream-memory write arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_S00  = 2'b01;
  localparam logic [1:0] GNT_S01  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// mem_arb_pick : combinational 2-way picker; MEM_ARB_FIXED_PRIO_EN selects
//                fixed s00 priority instead of round-robin on a tie
// Revision     : 1.0
// ============================================================================
`default_nettype none

module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] pick
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    pick = GNT_NONE;
    if (req[0])      pick = GNT_S00;
    else if (req[1]) pick = GNT_S01;
  end
`else
  // last_grant: 0 = s00 served last, 1 = s01 served last
  always_comb begin
    pick = GNT_NONE;
    case (req)
      2'b01:   pick = GNT_S00;
      2'b10:   pick = GNT_S01;
      2'b11:   pick = last_grant ? GNT_S00 : GNT_S01;
      default: pick = GNT_NONE;
    endcase
  end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_wr_arbiter.sv
// ============================================================================
// mem_wr_arbiter : packet-granular 2:1 AXI-Stream write arbiter in front of the
//                  stream memory; MEM_ARB_FIXED_PRIO_EN gives fixed s00 priority
// Revision       : 1.0
// ============================================================================
`default_nettype none

module mem_wr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                    axis_aclk,
  input  logic                    axis_aresetn,
  input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                    s00_axis_tvalid,
  input  logic                    s00_axis_tlast,
  output logic                    s00_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
  input  logic                    s01_axis_tvalid,
  input  logic                    s01_axis_tlast,
  output logic                    s01_axis_tready,
  output logic [DATA_WIDTH-1:0]   m02_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m02_axis_tstrb,
  output logic                    m02_axis_tvalid,
  output logic                    m02_axis_tlast,
  input  logic                    m02_axis_tready,
  output logic [1:0]              grant,
  output logic [CNT_WIDTH-1:0]    beat_cnt,
  output logic [CNT_WIDTH-1:0]    pkt_cnt0,
  output logic [CNT_WIDTH-1:0]    pkt_cnt1
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [CNT_WIDTH-1:0] pkt_cnt1_q, pkt_cnt1_d;
  logic                 last_grant_q;
  logic [1:0]           pick;
  logic                 xfer;

  mem_arb_pick u_pick (
    .req        ({s01_axis_tvalid, s00_axis_tvalid}),
    .last_grant (last_grant_q),
    .pick       (pick)
  );

  // Pass-through mux: purely a function of the registered owner.
  always_comb begin
    m02_axis_tdata  = '0;
    m02_axis_tstrb  = '0;
    m02_axis_tvalid = 1'b0;
    m02_axis_tlast  = 1'b0;
    s00_axis_tready = 1'b0;
    s01_axis_tready = 1'b0;
    grant           = GNT_NONE;
    case (state_q)
      GRANT0: begin
        m02_axis_tdata  = s00_axis_tdata;
        m02_axis_tstrb  = s00_axis_tstrb;
        m02_axis_tvalid = s00_axis_tvalid;
        m02_axis_tlast  = s00_axis_tlast;
        s00_axis_tready = m02_axis_tready;
        grant           = GNT_S00;
      end
      GRANT1: begin
        m02_axis_tdata  = s01_axis_tdata;
        m02_axis_tstrb  = s01_axis_tstrb;
        m02_axis_tvalid = s01_axis_tvalid;
        m02_axis_tlast  = s01_axis_tlast;
        s01_axis_tready = m02_axis_tready;
        grant           = GNT_S01;
      end
      default: ;
    endcase
  end

  assign xfer = m02_axis_tvalid && m02_axis_tready;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
    case (state_q)
      IDLE: begin
        if (pick == GNT_S00)      state_d = GRANT0;
        else if (pick == GNT_S01) state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (xfer) begin
          if (m02_axis_tlast) begin
            beat_cnt_d = '0;
            state_d    = IDLE;
            if (state_q == GRANT0) pkt_cnt0_d = pkt_cnt0_q + CNT_ONE;
            else                   pkt_cnt1_d = pkt_cnt1_q + CNT_ONE;
          end else if (beat_cnt_q != CNT_MAX) begin
            beat_cnt_d = beat_cnt_q + CNT_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign last_grant_q = 1'b1;
`else
  logic last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (xfer && m02_axis_tlast) last_grant_d = (state_q == GRANT1);
  end

  // Reset to "s01 served last" so s00 wins the first tie.
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) last_grant_q <= 1'b1;
    else               last_grant_q <= last_grant_d;
  end
`endif

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
    end
  end

  assign beat_cnt = beat_cnt_q;
  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_wr_arbiter.sv
// ============================================================================
// tb_mem_wr_arbiter : randomized bench for mem_wr_arbiter against a
//                     packet-level reference model (CNT_WIDTH = 4)
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_mem_wr_arbiter;

  localparam int DW = 32;
  localparam int CW = 4;
`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic [DW-1:0] d [2];
  logic [3:0]    s [2];
  logic          v [2];
  logic          l [2];
  logic          tready;

  logic          s00_tready, s01_tready;
  logic [DW-1:0] m02_tdata;
  logic [3:0]    m02_tstrb;
  logic          m02_tvalid, m02_tlast;
  logic [1:0]    grant;
  logic [CW-1:0] beat_cnt, pkt_cnt0, pkt_cnt1;

  mem_wr_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .axis_aclk       (clk),
    .axis_aresetn    (rstn),
    .s00_axis_tdata  (d[0]),
    .s00_axis_tstrb  (s[0]),
    .s00_axis_tvalid (v[0]),
    .s00_axis_tlast  (l[0]),
    .s00_axis_tready (s00_tready),
    .s01_axis_tdata  (d[1]),
    .s01_axis_tstrb  (s[1]),
    .s01_axis_tvalid (v[1]),
    .s01_axis_tlast  (l[1]),
    .s01_axis_tready (s01_tready),
    .m02_axis_tdata  (m02_tdata),
    .m02_axis_tstrb  (m02_tstrb),
    .m02_axis_tvalid (m02_tvalid),
    .m02_axis_tlast  (m02_tlast),
    .m02_axis_tready (tready),
    .grant           (grant),
    .beat_cnt        (beat_cnt),
    .pkt_cnt0        (pkt_cnt0),
    .pkt_cnt1        (pkt_cnt1)
  );

  logic [53:0] dut_vec;
  assign dut_vec = {grant, s00_tready, s01_tready, m02_tvalid, m02_tlast,
                    m02_tdata, m02_tstrb, beat_cnt, pkt_cnt0, pkt_cnt1};

  int total = 0;
  int bad   = 0;

  // Producer state: packet length queues, remaining beats, stall counters
  int qa[$];
  int qb[$];
  int rem [2];
  int hold [2];
  int pv [2];
  int xcount [2];

  // Reference model: owner 0 = idle, 1 = s00, 2 = s01
  int m_owner, m_last, m_beat, m_pkt0, m_pkt1;

  function automatic logic [53:0] exp_vec();
    logic [1:0] g; logic r0, r1, mv, ml; logic [DW-1:0] md; logic [3:0] ms;
    g = 2'b00; r0 = 1'b0; r1 = 1'b0; mv = 1'b0; ml = 1'b0; md = '0; ms = '0;
    if (m_owner == 1) begin
      g = 2'b01; r0 = tready; mv = v[0]; ml = l[0]; md = d[0]; ms = s[0];
    end else if (m_owner == 2) begin
      g = 2'b10; r1 = tready; mv = v[1]; ml = l[1]; md = d[1]; ms = s[1];
    end
    return {g, r0, r1, mv, ml, md, ms, 4'(m_beat), 4'(m_pkt0), 4'(m_pkt1)};
  endfunction

  function automatic bit busy();
    return (rem[0] > 0) || (rem[1] > 0) || (qa.size() > 0) || (qb.size() > 0) ||
           v[0] || v[1] || (m_owner != 0);
  endfunction

  task automatic clear_producers();
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; l[i] = 1'b0; d[i] = '0; s[i] = '0;
      rem[i] = 0; hold[i] = 0; pv[i] = 100; xcount[i] = 0;
    end
    qa.delete();
    qb.delete();
  endtask

  task automatic gen_inputs();
    for (int i = 0; i < 2; i++) begin
      if (!v[i]) begin
        if (rem[i] == 0) begin
          if (i == 0 && qa.size() > 0)      rem[0] = qa.pop_front();
          else if (i == 1 && qb.size() > 0) rem[1] = qb.pop_front();
        end
        if (hold[i] > 0) hold[i]--;
        else if (rem[i] > 0 && int'($urandom_range(99)) < pv[i]) begin
          v[i] = 1'b1;
          d[i] = $urandom;
          s[i] = 4'($urandom);
          l[i] = (rem[i] == 1);
        end
      end
    end
  endtask

  // Clock edge, then update model and producers from the inputs seen at it.
  task automatic advance();
    int x;
    @(posedge clk);
    #1;
    if (!rstn) begin
      m_owner = 0; m_last = 1; m_beat = 0; m_pkt0 = 0; m_pkt1 = 0;
    end else if (m_owner == 0) begin
      if (v[0] && v[1])  m_owner = (FIXED || m_last == 1) ? 1 : 2;
      else if (v[0])     m_owner = 1;
      else if (v[1])     m_owner = 2;
    end else begin
      x = m_owner - 1;
      if (v[x] && tready) begin
        xcount[x]++;
        rem[x]--;
        if (l[x]) begin
          if (x == 0) m_pkt0 = (m_pkt0 + 1) % 16;
          else        m_pkt1 = (m_pkt1 + 1) % 16;
          m_last  = x;
          m_beat  = 0;
          m_owner = 0;
        end else if (m_beat < 15) begin
          m_beat++;
        end
        v[x] = 1'b0;
        l[x] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tready = 1'b0;
    clear_producers();
    advance();
    advance();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if (dut_vec !== 54'h0) begin
      bad++; $display("FAIL reset_state got=%h exp=%h", dut_vec, 54'h0);
    end
    total++;
    if (dut_vec !== exp_vec()) begin
      bad++; $display("FAIL reset_model got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_single();
    do_reset();
    qa.push_back(4);
    tready = 1'b1;
    for (int c = 0; c < 50 && busy(); c++) begin
      gen_inputs(); #1;
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL single c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
      advance();
    end
    total++;
    if (busy() || xcount[0] != 4 || pkt_cnt0 !== 4'd1 || beat_cnt !== 4'd0) begin
      bad++; $display("FAIL single_end beats=%0d pkt0=%0d beat=%0d exp 4/1/0",
                      xcount[0], pkt_cnt0, beat_cnt);
    end
  endtask

  task automatic test_tie_rr();
    logic [1:0] order[$];
    logic [1:0] exp_order [4];
    logic [1:0] pg;
    do_reset();
    qa.push_back(3); qa.push_back(3);
    qb.push_back(3); qb.push_back(3);
    tready = 1'b1;
    pg = 2'b00;
    if (FIXED) exp_order = '{2'b01, 2'b01, 2'b10, 2'b10};
    else       exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int c = 0; c < 100 && busy(); c++) begin
      gen_inputs(); #1;
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL tie c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
      if (grant != 2'b00 && pg == 2'b00) order.push_back(grant);
      pg = grant;
      advance();
    end
    total++;
    if (busy() || order.size() != 4) begin
      bad++; $display("FAIL tie_count grants=%0d exp=4", order.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (order[k] !== exp_order[k]) begin
          bad++; $display("FAIL tie_order k=%0d got=%b exp=%b", k, order[k], exp_order[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int gcnt, dg;
    do_reset();
    qb.push_back(4);
    gcnt = 0; dg = 0;
    for (int c = 0; c < 50 && busy(); c++) begin
      tready = (m_owner == 2) && (gcnt % 2 == 1);
      gen_inputs(); #1;
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL bp c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
      if (m_owner == 2) gcnt++;
      if (grant == 2'b10) dg++;
      advance();
    end
    total++;
    if (busy() || dg != 8) begin
      bad++; $display("FAIL bp_cycles got=%0d exp=8", dg);
    end
  endtask

  task automatic test_stall();
    int stall_cyc;
    bit stalled;
    do_reset();
    qa.push_back(6);
    qb.push_back(2);
    tready = 1'b1;
    stall_cyc = 0; stalled = 1'b0;
    for (int c = 0; c < 80 && busy(); c++) begin
      gen_inputs(); #1;
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL stall c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
      if (grant == 2'b01 && !m02_tvalid) stall_cyc++;
      advance();
      if (xcount[0] == 2 && !stalled) begin hold[0] = 5; stalled = 1'b1; end
    end
    total++;
    if (busy() || stall_cyc != 5) begin
      bad++; $display("FAIL stall_cycles got=%0d exp=5", stall_cyc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    qa.push_back(4);
    tready = 1'b1;
    for (int c = 0; c < 30 && xcount[0] < 2; c++) begin
      gen_inputs(); #1;
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL rstmid c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
      advance();
    end
    rstn = 1'b0;
    clear_producers();
    advance();
    #1;
    total++;
    if (grant !== 2'b00 || beat_cnt !== 4'd0 || s00_tready !== 1'b0 ||
        s01_tready !== 1'b0 || m02_tvalid !== 1'b0) begin
      bad++; $display("FAIL rstmid_abort got grant=%b beat=%0d rdy=%b%b val=%b exp 00/0/00/0",
                      grant, beat_cnt, s00_tready, s01_tready, m02_tvalid);
    end
    rstn = 1'b1;
  endtask

  task automatic test_sat_wrap();
    bit seen;
    do_reset();
    qb.push_back(20);
    tready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 60 && busy(); c++) begin
      gen_inputs(); #1;
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL sat c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
      advance();
      if (xcount[1] == 19 && !seen) begin
        seen = 1'b1;
        total++;
        if (beat_cnt !== 4'd15) begin
          bad++; $display("FAIL sat_beat got=%0d exp=15", beat_cnt);
        end
      end
    end
    for (int k = 0; k < 17; k++) qa.push_back(1);
    for (int c = 0; c < 100 && busy(); c++) begin
      gen_inputs(); #1;
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL wrap c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
      advance();
    end
    total++;
    if (busy() || pkt_cnt0 !== 4'd1 || pkt_cnt1 !== 4'd1) begin
      bad++; $display("FAIL wrap_cnt got pkt0=%0d pkt1=%0d exp 1/1", pkt_cnt0, pkt_cnt1);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      qa.push_back(int'($urandom_range(1, 6)));
      qb.push_back(int'($urandom_range(1, 6)));
    end
    for (int c = 0; c < 3000 && busy(); c++) begin
      pv[0] = int'($urandom_range(30, 100));
      pv[1] = int'($urandom_range(30, 100));
      tready = ($urandom_range(99) < 70);
      gen_inputs(); #1;
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
      advance();
    end
    total++;
    if (busy()) begin
      bad++; $display("FAIL random_timeout got=busy exp=drained");
    end
  endtask

  initial begin
    rstn = 1'b0;
    tready = 1'b0;
    m_owner = 0; m_last = 1; m_beat = 0; m_pkt0 = 0; m_pkt1 = 0;
    clear_producers();
    test_reset();
    test_single();
    test_tie_rr();
    test_backpressure();
    test_stall();
    test_reset_mid();
    test_sat_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
